// File: rtl/inst_fetch_mem_pkg.sv
// Shared NPC fetch-side definitions: FSM state encoding, reset PC,
// canonical NOP and default fetch latency.
package inst_fetch_mem_pkg;

  typedef enum logic [1:0] {
    ST_READ    = 2'd0,
    ST_RESP    = 2'd1,
    ST_WAIT_PC = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          LATENCY_DEF = 2;

  // A fetch address is legal only on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_mem_if.sv
// Bundle between the fetch stage and its neighbours: next-PC input from
// writeback, SRAM read port, and the instruction handshake toward the IFU.
interface inst_fetch_mem_if;

  logic [31:0] pc_in;
  logic        pc_in_valid;
  logic        pc_in_ready;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        fetch_err;
  logic        mem_IFU_valid;
  logic        IFU_mem_ready;

  // Fetch stage side.
  modport master (
    input  pc_in, pc_in_valid, rd_data, IFU_mem_ready,
    output pc_in_ready, rd_en, rd_addr, inst_out, pc_out, fetch_err, mem_IFU_valid
  );

  // Environment side: writeback, SRAM and IFU.
  modport slave (
    output pc_in, pc_in_valid, rd_data, IFU_mem_ready,
    input  pc_in_ready, rd_en, rd_addr, inst_out, pc_out, fetch_err, mem_IFU_valid
  );

endinterface

// File: rtl/inst_fetch_mem.sv
// Fetch stage: holds the architectural PC, issues one SRAM read per
// instruction, waits a fixed latency and hands the word to the IFU.
module inst_fetch_mem #(
  parameter logic [31:0] RESET_PC = inst_fetch_mem_pkg::RESET_PC,
  parameter int          LATENCY  = inst_fetch_mem_pkg::LATENCY_DEF,
  parameter int          CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_mem_if.master ifm
);
  import inst_fetch_mem_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  if (LATENCY < 2 || LATENCY > 15 || (1 << CNT_W) <= LATENCY) begin : g_bad_cfg
    $error("inst_fetch_mem: LATENCY must be 2..15 and fit in CNT_W bits");
  end

  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       pc_q;
  logic [31:0]       inst_q;
  logic              post_rst_q;   // masks the read strobe in the first cycle out of reset
  logic              valid_q;
  logic [31:0]       inst_out_q;
  logic [31:0]       pc_out_q;
  logic              err_q;

  logic              aligned;
  logic [31:0]       inst_d;

  assign aligned = is_word_aligned(pc_q[1:0]);

  // Read data arrives the cycle after the strobe (cnt==1); with LATENCY=2 that
  // is also the cycle the response is launched, so forward it directly.
  assign inst_d = (cnt_q == ONE_CNT) ? ifm.rd_data : inst_q;

  assign ifm.rd_en         = (state_q == ST_READ) && !post_rst_q && (cnt_q == '0) && aligned;
  assign ifm.rd_addr       = {pc_q[31:2], 2'b00};
  assign ifm.pc_in_ready   = (state_q == ST_WAIT_PC);
  assign ifm.mem_IFU_valid = valid_q;
  assign ifm.inst_out      = inst_out_q;
  assign ifm.pc_out        = pc_out_q;
  assign ifm.fetch_err     = err_q;

  // Fetch FSM with latency counter and registered IFU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_READ;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      post_rst_q <= 1'b1;
      valid_q    <= 1'b0;
      inst_out_q <= '0;
      pc_out_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_READ: begin
          if (post_rst_q) begin
            post_rst_q <= 1'b0;
          end else begin
            if (cnt_q == ONE_CNT && aligned) begin
              inst_q <= ifm.rd_data;
            end
            if (cnt_q == LAST_CNT) begin
              state_q    <= ST_RESP;
              valid_q    <= 1'b1;
              pc_out_q   <= pc_q;
              inst_out_q <= aligned ? inst_d : NOP_INST;
              err_q      <= !aligned;
            end else begin
              cnt_q <= cnt_q + ONE_CNT;
            end
          end
        end
        ST_RESP: begin
          if (ifm.IFU_mem_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_WAIT_PC;
          end
        end
        ST_WAIT_PC: begin
          if (ifm.pc_in_valid) begin
            pc_q    <= ifm.pc_in;
            cnt_q   <= '0;
            state_q <= ST_READ;
          end
        end
        default: begin
          state_q <= ST_READ;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
